// File: rtl/regfile_multiport.sv
// Multi-port register file with hardwired zero register and a sequential clear engine (one entry per clock, busy while running).
// Reads are combinational (0 cycles); writes land on the clock edge. While busy, writes and new clear requests are dropped.
// REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module regfile_multiport #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int READ_PORTS = 2,
  parameter int ZERO_REG   = 31
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] select,
  output logic [READ_PORTS*DATA_WIDTH-1:0] out,
  input  logic [DATA_WIDTH-1:0]            data_in,
  input  logic [ADDR_WIDTH-1:0]            address,
  input  logic                             write,
  input  logic                             clear,
  output logic                             busy
);

  localparam int                    DEPTH    = 2 ** ADDR_WIDTH;
  localparam bit                    ZERO_EN  = (ZERO_REG >= 0) && (ZERO_REG < DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
  logic                    wr_en;
  logic                    clr_en;
  logic                    addr_is_zero;
  logic [DATA_WIDTH-1:0]   regs [DEPTH];

  assign addr_is_zero = ZERO_EN && (address == ZERO_IDX);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_en     = 1'b0;
    clr_en    = 1'b0;
    case (state)
      IDLE: begin
        // A write arriving with the clear request still completes.
        wr_en = write && !addr_is_zero;
        if (clear) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        clr_en  = 1'b1;
        cnt_nxt = cnt + ADDR_WIDTH'(1);
        if (cnt == LAST_IDX) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign busy = (state == CLEAR);

  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        regs[g] <= '0;
      end else if (wr_en && (address == ADDR_WIDTH'(g))) begin
        regs[g] <= data_in;
      end else if (clr_en && (cnt == ADDR_WIDTH'(g))) begin
        regs[g] <= '0;
      end
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] sel;
    logic [DATA_WIDTH-1:0] rd_dat;

    assign sel = select[p*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rd_dat = regs[sel];
      if (ZERO_EN && (sel == ZERO_IDX)) begin
        rd_dat = '0;
      end
`ifdef REGFILE_BYPASS_EN
      // wr_en already excludes the zero register and any non-IDLE state.
      if (wr_en && (address == sel)) begin
        rd_dat = data_in;
      end
`else
`endif
    end

    assign out[p*DATA_WIDTH +: DATA_WIDTH] = rd_dat;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed, table-driven bench for regfile_multiport (default parameters).
module tb_regfile_multiport;

  logic         clock;
  logic         reset;
  logic [9:0]   select;
  logic [127:0] out;
  logic [63:0]  data_in;
  logic [4:0]   address;
  logic         write;
  logic         clear;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  regfile_multiport #(
    .DATA_WIDTH(64),
    .ADDR_WIDTH(5),
    .READ_PORTS(2),
    .ZERO_REG  (31)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .select (select),
    .out    (out),
    .data_in(data_in),
    .address(address),
    .write  (write),
    .clear  (clear),
    .busy   (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [63:0] din;
    logic [4:0]  s0;
    logic [4:0]  s1;
    logic [63:0] e0;
    logic [63:0] e1;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sel(input logic [4:0] a0, input logic [4:0] a1);
    select = {a1, a0};
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d);
    write   = 1'b1;
    address = a;
    data_in = d;
    tick();
    write   = 1'b0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rd(input int p);
    return out[p*64 +: 64];
  endfunction

  initial begin
    int n;
    logic [63:0] exp_byp;

    vecs[0] = '{1'b1, 5'd1,  64'hDEAD_BEEF_0123_4567, 5'd0,  5'd1,  64'h0,      64'hDEAD_BEEF_0123_4567};
    vecs[1] = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd1,  64'h0,      64'hDEAD_BEEF_0123_4567};
    vecs[2] = '{1'b1, 5'd2,  64'h1234,                5'd2,  5'd2,  64'h1234,   64'h1234};
    vecs[3] = '{1'b1, 5'd0,  64'hAAAA,                5'd0,  5'd31, 64'hAAAA,   64'h0};
    vecs[4] = '{1'b0, 5'd2,  64'hBAD,                 5'd2,  5'd0,  64'h1234,   64'hAAAA};
    vecs[5] = '{1'b1, 5'd30, 64'h3030,                5'd30, 5'd29, 64'h3030,   64'h0};
    vecs[6] = '{1'b1, 5'd1,  64'h1111,                5'd1,  5'd30, 64'h1111,   64'h3030};

    reset   = 1'b0;
    select  = '0;
    data_in = '0;
    address = '0;
    write   = 1'b0;
    clear   = 1'b0;

    // Reset state, during and after release
    tick();
    sel(5'd0, 5'd1);
    check("rst_out0", rd(0), 64'h0);
    check("rst_out1", rd(1), 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    reset = 1'b1;
    tick();
    sel(5'd7, 5'd30);
    check("post_rst_out0", rd(0), 64'h0);
    check("post_rst_out1", rd(1), 64'h0);
    check("post_rst_busy", {63'h0, busy}, 64'h0);

    // Write/read table
    for (int i = 0; i < 7; i++) begin
      write   = vecs[i].wr;
      address = vecs[i].addr;
      data_in = vecs[i].din;
      tick();
      write = 1'b0;
      sel(vecs[i].s0, vecs[i].s1);
      check($sformatf("vec%0d_out0", i), rd(0), vecs[i].e0);
      check($sformatf("vec%0d_out1", i), rd(1), vecs[i].e1);
    end

    // Sequential clear
    for (int i = 0; i < 31; i++) begin
      wr(5'(i), 64'(i + 100));
    end
    sel(5'd2, 5'd20);
    check("prefill_r2", rd(0), 64'd102);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      if (n == 10) begin
        check("mid_clear_r2", rd(0), 64'h0);
        check("mid_clear_r20", rd(1), 64'd120);
      end
      if (n == 12) begin
        write   = 1'b1;
        address = 5'd5;
        data_in = 64'h55;
      end
      tick();
      write = 1'b0;
      n++;
    end
    check("busy_cycles", 64'(n), 64'd32);
    for (int i = 0; i < 32; i++) begin
      sel(5'(i), 5'(31 - i));
      check($sformatf("cleared_p0_r%0d", i), rd(0), 64'h0);
      check($sformatf("cleared_p1_r%0d", 31 - i), rd(1), 64'h0);
    end
    sel(5'd5, 5'd5);
    check("dropped_write_r5", rd(0), 64'h0);

    // Reset in the middle of a clear
    wr(5'd25, 64'h77);
    wr(5'd3, 64'h33);
    sel(5'd25, 5'd3);
    check("pre_abort_r25", rd(0), 64'h77);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (10) tick();
    check("abort_busy_before", {63'h0, busy}, 64'h1);
    #1;
    reset = 1'b0;
    #1;
    check("abort_busy", {63'h0, busy}, 64'h0);
    check("abort_r25", rd(0), 64'h0);
    reset = 1'b1;
    tick();
    wr(5'd3, 64'h7);
    wr(5'd20, 64'h99);
    repeat (3) tick();
    sel(5'd3, 5'd20);
    check("after_abort_r3", rd(0), 64'h7);
    check("no_resume_r20", rd(1), 64'h99);
    check("no_resume_busy", {63'h0, busy}, 64'h0);

    // Same-cycle visibility of a write
    wr(5'd4, 64'h11);
`ifdef REGFILE_BYPASS_EN
    exp_byp = 64'hA5;
`else
    exp_byp = 64'h11;
`endif
    write   = 1'b1;
    address = 5'd4;
    data_in = 64'hA5;
    sel(5'd4, 5'd3);
    check("same_cycle_r4", rd(0), exp_byp);
    check("same_cycle_other", rd(1), 64'h7);
    tick();
    write = 1'b0;
    #1;
    check("next_cycle_r4", rd(0), 64'hA5);
    write   = 1'b1;
    address = 5'd31;
    data_in = 64'hFF;
    sel(5'd4, 5'd31);
    check("same_cycle_zero", rd(1), 64'h0);
    tick();
    write = 1'b0;
    #1;
    check("after_zero_write", rd(1), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
